// File: rtl/ima_adpcm_pkg.sv
// Shared tables, limits and per-channel state type for the IMA ADPCM codec blocks.
package ima_adpcm_pkg;

    localparam int MAX_IDX = 88;
    localparam int PCM_MAX = 32767;
    localparam int PCM_MIN = -32768;

    localparam int STEP_TBL [89] = '{
            7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
           19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
           50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
          130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
          337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
          876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
         2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
         5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    // +8 does not fit a signed 4-bit value, so the entries are 5 bits wide.
    localparam logic signed [4:0] IDX_TBL [16] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8,
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef struct packed {
        logic signed [15:0] pred;
        logic [6:0]         idx;
    } ch_state_t;

endpackage

// File: rtl/ima_adpcm_step.sv
// One IMA ADPCM predictor/step-index update; purely combinational, shared with the encoder.
module ima_adpcm_step
    import ima_adpcm_pkg::*;
(
    input  ch_state_t  st_i,
    input  logic [3:0] code_i,
    output ch_state_t  st_o
);

    localparam logic signed [17:0] SAT_HI  = 18'(PCM_MAX);
    localparam logic signed [17:0] SAT_LO  = 18'(PCM_MIN);
    localparam logic [6:0]         IDX_TOP = 7'(MAX_IDX);
    localparam logic signed [7:0]  IDX_TOP_S = 8'(MAX_IDX);

    logic [6:0]         idx_safe;
    logic [15:0]        step;
    logic [16:0]        diff;
    logic signed [17:0] pred_ext;
    logic signed [17:0] sum;
    logic signed [4:0]  idx_adj;
    logic signed [7:0]  idx_sum;

    always_comb begin
        idx_safe = (st_i.idx > IDX_TOP) ? IDX_TOP : st_i.idx;
        step     = 16'(STEP_TBL[idx_safe]);

        diff = 17'(step >> 3);
        if (code_i[2]) diff = diff + 17'(step);
        if (code_i[1]) diff = diff + 17'(step >> 1);
        if (code_i[0]) diff = diff + 17'(step >> 2);

        pred_ext = $signed({{2{st_i.pred[15]}}, st_i.pred});
        if (code_i[3]) sum = pred_ext - $signed({1'b0, diff});
        else           sum = pred_ext + $signed({1'b0, diff});

        if (sum > SAT_HI)      st_o.pred = 16'sh7FFF;
        else if (sum < SAT_LO) st_o.pred = 16'sh8000;
        else                   st_o.pred = sum[15:0];

        idx_adj = IDX_TBL[code_i];
        idx_sum = $signed({1'b0, idx_safe}) + $signed({{3{idx_adj[4]}}, idx_adj});
        if (idx_sum < 8'sd0)          st_o.idx = 7'd0;
        else if (idx_sum > IDX_TOP_S) st_o.idx = IDX_TOP;
        else                          st_o.idx = idx_sum[6:0];
    end

endmodule

// File: rtl/ima_adpcm_decoder_mc.sv
// Multi-channel IMA ADPCM decoder with valid/ready streams and per-channel sop/eop framing.
// Optional header-load beats are enabled by defining ADPCM_HDR_LOAD_EN.
module ima_adpcm_decoder_mc
    import ima_adpcm_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [3:0]         in_code,
`ifdef ADPCM_HDR_LOAD_EN
    input  logic               in_hdr,
    input  logic signed [15:0] in_hdr_pred,
    input  logic [6:0]         in_hdr_idx,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [CH_W-1:0]    out_ch,
    output logic signed [15:0] out_sample,
    output logic               err_o
);

    ch_state_t          st_q [N_CH];
    ch_state_t          st_d [N_CH];
    logic [N_CH-1:0]    active_q, active_d;

    logic               out_valid_q, out_valid_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic signed [15:0] out_sample_q, out_sample_d;
    logic               err_q, err_d;

    logic               accept;
    logic               ch_ok;
    logic               is_hdr;
    logic               do_dec;
    ch_state_t          hdr_st;
    ch_state_t          dec_in;
    ch_state_t          dec_out;

    assign in_ready = !out_valid_q | out_ready;

    // sop restarts the channel from zero state before this beat's code is applied.
    assign dec_in = in_sop ? '0 : st_q[in_ch];

    ima_adpcm_step u_step (
        .st_i   (dec_in),
        .code_i (in_code),
        .st_o   (dec_out)
    );

    always_comb begin
        st_d         = st_q;
        active_d     = active_q;
        out_valid_d  = out_valid_q & !out_ready;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_ch_d     = out_ch_q;
        out_sample_d = out_sample_q;

`ifdef ADPCM_HDR_LOAD_EN
        is_hdr      = in_hdr;
        hdr_st.pred = in_hdr_pred;
        hdr_st.idx  = (in_hdr_idx > 7'(MAX_IDX)) ? 7'(MAX_IDX) : in_hdr_idx;
`else
        is_hdr      = 1'b0;
        hdr_st      = '0;
`endif

        accept = in_valid & in_ready;
        ch_ok  = (int'(in_ch) < N_CH);
        do_dec = accept & ch_ok & !is_hdr & (in_sop | active_q[in_ch]);
        // Codes outside a packet (or on a nonexistent channel) are swallowed and flagged.
        err_d  = accept & !is_hdr & !do_dec;

        if (accept & is_hdr & ch_ok) begin
            st_d[in_ch]     = hdr_st;
            active_d[in_ch] = 1'b1;
        end

        if (do_dec) begin
            st_d[in_ch]     = dec_out;
            active_d[in_ch] = !in_eop;
            out_valid_d     = 1'b1;
            out_sop_d       = in_sop;
            out_eop_d       = in_eop;
            out_ch_d        = in_ch;
            out_sample_d    = dec_out.pred;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) st_q[i] <= '0;
            active_q     <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
            active_q     <= active_d;
            out_valid_q  <= out_valid_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
            err_q        <= err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ima_adpcm_decoder_mc.sv
// Bench for ima_adpcm_decoder_mc: vector table, hand-written stall/saturation/reset sequences,
// and randomized traffic checked by a negedge scoreboard against an arithmetic reference model.
module tb_ima_adpcm_decoder_mc;

    localparam int N_CH = 2;
    localparam int CH_W = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_sop;
    logic               in_eop;
    logic [CH_W-1:0]    in_ch;
    logic [3:0]         in_code;
`ifdef ADPCM_HDR_LOAD_EN
    logic               in_hdr;
    logic signed [15:0] in_hdr_pred;
    logic [6:0]         in_hdr_idx;
`endif
    logic               out_valid;
    logic               out_ready;
    logic               out_sop;
    logic               out_eop;
    logic [CH_W-1:0]    out_ch;
    logic signed [15:0] out_sample;
    logic               err_o;

    always #5 clk = ~clk;

    ima_adpcm_decoder_mc #(.N_CH(N_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_ch       (in_ch),
        .in_code     (in_code),
`ifdef ADPCM_HDR_LOAD_EN
        .in_hdr      (in_hdr),
        .in_hdr_pred (in_hdr_pred),
        .in_hdr_idx  (in_hdr_idx),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_ch      (out_ch),
        .out_sample  (out_sample),
        .err_o       (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int step_tbl [89] = '{
            7,     8,     9,    10,    11,    12,    13,    14,    16,    17,
           19,    21,    23,    25,    28,    31,    34,    37,    41,    45,
           50,    55,    60,    66,    73,    80,    88,    97,   107,   118,
          130,   143,   157,   173,   190,   209,   230,   253,   279,   307,
          337,   371,   408,   449,   494,   544,   598,   658,   724,   796,
          876,   963,  1060,  1166,  1282,  1411,  1552,  1707,  1878,  2066,
         2272,  2499,  2749,  3024,  3327,  3660,  4026,  4428,  4871,  5358,
         5894,  6484,  7132,  7845,  8630,  9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int idx_adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    int m_pred [N_CH];
    int m_idx  [N_CH];
    bit m_act  [N_CH];

    typedef struct {
        int ch;
        bit sop;
        bit eop;
        int sample;
    } exp_t;

    exp_t exp_q[$];
    bit   err_exp;

    task automatic model_beat();
        int   ch   = int'(in_ch);
        int   code = int'(in_code);
        bit   hdr  = 1'b0;
        int   step;
        int   diff;
        int   p;
        int   ni;
        exp_t e;
`ifdef ADPCM_HDR_LOAD_EN
        hdr = in_hdr;
`endif
        if (hdr) begin
`ifdef ADPCM_HDR_LOAD_EN
            m_pred[ch] = int'(in_hdr_pred);
            m_idx[ch]  = (int'(in_hdr_idx) > 88) ? 88 : int'(in_hdr_idx);
            m_act[ch]  = 1'b1;
`endif
        end else if (in_sop || m_act[ch]) begin
            if (in_sop) begin
                m_pred[ch] = 0;
                m_idx[ch]  = 0;
            end
            step = step_tbl[m_idx[ch]];
            diff = step / 8;
            if ((code & 4) != 0) diff += step;
            if ((code & 2) != 0) diff += step / 2;
            if ((code & 1) != 0) diff += step / 4;
            p = ((code & 8) != 0) ? m_pred[ch] - diff : m_pred[ch] + diff;
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
            ni = m_idx[ch] + idx_adj[code & 7];
            if (ni < 0)  ni = 0;
            if (ni > 88) ni = 88;
            m_pred[ch] = p;
            m_idx[ch]  = ni;
            m_act[ch]  = !in_eop;
            e.ch = ch; e.sop = in_sop; e.eop = in_eop; e.sample = p;
            exp_q.push_back(e);
        end else begin
            err_exp = 1'b1;
        end
    endtask

    // Scoreboard: observe both handshakes at the falling edge, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                m_pred[c] = 0;
                m_idx[c]  = 0;
                m_act[c]  = 1'b0;
            end
            exp_q.delete();
            err_exp = 1'b0;
        end else begin
            check("mon_err", int'(err_o), int'(err_exp));
            check("mon_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("mon_sample", int'(out_sample), exp_q[0].sample);
                check("mon_ch", int'(out_ch), exp_q[0].ch);
                check("mon_sop", int'(out_sop), int'(exp_q[0].sop));
                check("mon_eop", int'(out_eop), int'(exp_q[0].eop));
                if (out_ready) void'(exp_q.pop_front());
            end
            err_exp = 1'b0;
            if (in_valid && in_ready) model_beat();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int ch, input bit sop, input bit eop, input logic [3:0] code);
        in_ch    = CH_W'(ch);
        in_sop   = sop;
        in_eop   = eop;
        in_code  = code;
`ifdef ADPCM_HDR_LOAD_EN
        in_hdr   = 1'b0;
`endif
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send(input int ch, input bit sop, input bit eop, input logic [3:0] code);
        drive(ch, sop, eop, code);
        wait_accept();
    endtask

`ifdef ADPCM_HDR_LOAD_EN
    task automatic send_hdr(input int ch, input logic signed [15:0] pred, input logic [6:0] idx);
        drive(ch, 1'b0, 1'b0, 4'h0);
        in_hdr      = 1'b1;
        in_hdr_pred = pred;
        in_hdr_idx  = idx;
        wait_accept();
        in_hdr = 1'b0;
        $display("[TB] hdr ch%0d pred=%0d idx=%0d -> out_valid=%0d", ch, pred, idx, out_valid);
        check("hdr_no_output", int'(out_valid), 0);
    endtask
`endif

    typedef struct {
        int         ch;
        bit         sop;
        bit         eop;
        logic [3:0] code;
        bit         e_valid;
        int         e_sample;
        bit         e_err;
    } vec_t;

    vec_t vt [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1'b1, 1'b0, 4'h7, 1'b1,  11, 1'b0};
        vt[1] = '{0, 1'b0, 1'b0, 4'h7, 1'b1,  41, 1'b0};
        vt[2] = '{0, 1'b1, 1'b0, 4'h7, 1'b1,  11, 1'b0};
        vt[3] = '{1, 1'b1, 1'b0, 4'hF, 1'b1, -11, 1'b0};
        vt[4] = '{0, 1'b0, 1'b0, 4'h7, 1'b1,  41, 1'b0};
        vt[5] = '{1, 1'b0, 1'b1, 4'h0, 1'b1,  -9, 1'b0};
        vt[6] = '{1, 1'b0, 1'b0, 4'h3, 1'b0,   0, 1'b1};
        vt[7] = '{1, 1'b1, 1'b1, 4'h0, 1'b1,   0, 1'b0};
        vt[8] = '{1, 1'b0, 1'b0, 4'h5, 1'b0,   0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_ch     = '0;
        in_code   = 4'h0;
`ifdef ADPCM_HDR_LOAD_EN
        in_hdr      = 1'b0;
        in_hdr_pred = '0;
        in_hdr_idx  = '0;
`endif
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_out_ch", int'(out_ch), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            send(vt[i].ch, vt[i].sop, vt[i].eop, vt[i].code);
            $display("[TB] vec %0d ch%0d sop=%0d eop=%0d code=%h -> valid=%0d sample=%0d err=%0d",
                     i, vt[i].ch, vt[i].sop, vt[i].eop, vt[i].code, out_valid, out_sample, err_o);
            check("vec_valid", int'(out_valid), int'(vt[i].e_valid));
            check("vec_err", int'(err_o), int'(vt[i].e_err));
            if (vt[i].e_valid) begin
                check("vec_sample", int'(out_sample), vt[i].e_sample);
                check("vec_ch", int'(out_ch), vt[i].ch);
                check("vec_sop", int'(out_sop), int'(vt[i].sop));
                check("vec_eop", int'(out_eop), int'(vt[i].eop));
            end
        end
        @(posedge clk);
        #1;

        // Backpressure: sample held, input stalled, then resumes without loss or duplication.
        send(1, 1'b1, 1'b0, 4'h7);
        check("stall_first", int'(out_sample), 11);
        out_ready = 1'b0;
        drive(1, 1'b0, 1'b0, 4'h7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("[TB] stall cycle %0d in_ready=%0d out_valid=%0d sample=%0d",
                     i, in_ready, out_valid, out_sample);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_sample", int'(out_sample), 11);
            check("stall_sop", int'(out_sop), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("resume_valid", int'(out_valid), 1);
        check("resume_sample", int'(out_sample), 41);
        check("resume_sop", int'(out_sop), 0);
        @(posedge clk);
        #1;
        check("resume_drained", int'(out_valid), 0);

        // Saturation with back-to-back beats on ch0
        send(0, 1'b1, 1'b0, 4'h7);
        for (int i = 0; i < 200; i++) send(0, 1'b0, 1'b0, 4'h7);
        $display("[TB] saturate ch0 after 200 codes -> sample=%0d", out_sample);
        check("sat_max", int'(out_sample), 32767);
        send(0, 1'b0, 1'b1, 4'hF);
        $display("[TB] ch0 code F at idx 88 -> sample=%0d", out_sample);
        check("sat_idx88_down", int'(out_sample), -28669);
        check("sat_eop", int'(out_eop), 1);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_W'($urandom_range(0, N_CH - 1));
            in_sop    = ($urandom_range(0, 4) == 0);
            in_eop    = ($urandom_range(0, 5) == 0);
            in_code   = 4'($urandom_range(0, 15));
`ifdef ADPCM_HDR_LOAD_EN
            in_hdr      = ($urandom_range(0, 15) == 0);
            in_hdr_pred = 16'($urandom);
            in_hdr_idx  = 7'($urandom_range(0, 127));
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
`ifdef ADPCM_HDR_LOAD_EN
        in_hdr    = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] random phase done, %0d checks so far", n_tests);

`ifdef ADPCM_HDR_LOAD_EN
        send_hdr(0, -16'sd32760, 7'd88);
        send(0, 1'b0, 1'b0, 4'hF);
        $display("[TB] hdr ch0 then code F -> sample=%0d", out_sample);
        check("hdr_sat_min", int'(out_sample), -32768);
        send_hdr(1, 16'sd0, 7'd100);
        send(1, 1'b0, 1'b0, 4'h0);
        $display("[TB] hdr ch1 idx 100 then code 0 -> sample=%0d", out_sample);
        check("hdr_idx_clamp", int'(out_sample), 4095);
        send(1, 1'b1, 1'b1, 4'h7);
        check("hdr_sop_zero", int'(out_sample), 11);
        @(posedge clk);
        #1;
`endif

        // Asynchronous reset in the middle of a stalled packet
        out_ready = 1'b0;
        send(0, 1'b1, 1'b0, 4'h7);
        check("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-stream -> valid=%0d sample=%0d", out_valid, out_sample);
        check("arst_valid", int'(out_valid), 0);
        check("arst_sample", int'(out_sample), 0);
        check("arst_sop", int'(out_sop), 0);
        check("arst_err", int'(err_o), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(0, 1'b0, 1'b0, 4'h7);
        $display("[TB] ch0 non-sop after reset -> err=%0d valid=%0d", err_o, out_valid);
        check("post_rst_err", int'(err_o), 1);
        check("post_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("err_single_pulse", int'(err_o), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
